// File: rtl/modport_if.sv
// Wishbone (32-bit) to single-rank SDR SDRAM (16-bit) controller.
// Each access is one BL=2 burst with auto-precharge; the FSM owns power-up init and periodic refresh.
module modport_if #(
  parameter int APP_AW    = 26,
  parameter int dw        = 32,
  parameter int SDR_DW    = 16,
  parameter int SDR_BW    = 2,
  parameter int INIT_WAIT = 100,
  parameter int REF_INT   = 780,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 7,
  parameter int T_WR      = 2,
  parameter int CAS_LAT   = 3
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic [1:0]          cfg_colbits,
  input  logic                wb_stb,
  input  logic                wb_cyc,
  input  logic                wb_we,
  input  logic [APP_AW-1:0]   wb_addr,
  input  logic [3:0]          wb_sel,
  input  logic [dw-1:0]       wb_dati,
  input  logic [2:0]          wb_cti,
  output logic [dw-1:0]       wb_dato,
  output logic                wb_ack,
  output logic                sdr_cke,
  output logic                sdr_cs_n,
  output logic                sdr_ras_n,
  output logic                sdr_cas_n,
  output logic                sdr_we_n,
  output logic [SDR_BW-1:0]   sdr_dqm,
  output logic [1:0]          sdr_ba,
  output logic [12:0]         sdr_addr,
  inout  wire  [SDR_DW-1:0]   sdr_dq
);

  localparam logic [3:0] CMD_INH = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [3:0] S_INIT  = 4'd0;
  localparam logic [3:0] S_WRP   = 4'd1;
  localparam logic [3:0] S_WRFC1 = 4'd2;
  localparam logic [3:0] S_WRFC2 = 4'd3;
  localparam logic [3:0] S_WMRS  = 4'd4;
  localparam logic [3:0] S_IDLE  = 4'd5;
  localparam logic [3:0] S_WREF  = 4'd6;
  localparam logic [3:0] S_ACC   = 4'd7;
  localparam logic [3:0] S_ACK   = 4'd8;

  // Counter values are "cycles since the last command minus one" at the edge that issues the next step.
  localparam logic [15:0] L_INIT   = 16'(INIT_WAIT);
  localparam logic [15:0] L_RP     = 16'(T_RP - 1);
  localparam logic [15:0] L_RFC    = 16'(T_RFC - 1);
  localparam logic [15:0] L_CMD    = 16'(T_RCD - 1);
  localparam logic [15:0] L_BEAT1  = 16'(T_RCD);
  localparam logic [15:0] L_RD_CAP = 16'(T_RCD + CAS_LAT);
  localparam logic [15:0] L_RACK   = 16'(T_RCD + CAS_LAT + 1);
  localparam logic [15:0] L_WACK   = 16'(T_RCD + T_WR + T_RP);
  localparam logic [15:0] L_REF    = 16'(REF_INT - 1);

  logic [3:0]        r_state;
  logic [15:0]       r_cnt;
  logic              r_cke;
  logic [3:0]        r_cmd;
  logic [SDR_BW-1:0] r_dqm;
  logic [1:0]        r_ba;
  logic [12:0]       r_addr;
  logic [SDR_DW-1:0] r_dq;
  logic              r_dq_oe;
  logic              r_ack;
  logic [dw-1:0]     r_dato;
  logic [SDR_DW-1:0] r_rd_lo;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [dw-1:0]     r_dati;
  logic [10:0]       r_col;
  logic              r_ref_en;
  logic [15:0]       r_ref_cnt;
  logic              r_ref_pend;

  logic [31:0]       w_h;
  logic [3:0]        w_c;
  logic [10:0]       w_col;
  logic [1:0]        w_ba;
  logic [12:0]       w_row;
  logic              w_unused;

  // Halfword address split as column | bank | row, with the column width chosen at run time.
  assign w_h      = 32'({wb_addr[APP_AW-1:2], 1'b0});
  assign w_c      = 4'd8 + {2'b00, cfg_colbits};
  assign w_col    = 11'(w_h & ((32'd1 << w_c) - 32'd1));
  assign w_ba     = 2'(w_h >> w_c);
  assign w_row    = 13'(w_h >> (w_c + 4'd2));
  assign w_unused = ^{wb_cti, wb_addr[1:0]};

  assign sdr_cke                                  = r_cke;
  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = r_cmd;
  assign sdr_dqm                                  = r_dqm;
  assign sdr_ba                                   = r_ba;
  assign sdr_addr                                 = r_addr;
  assign sdr_dq                                   = r_dq_oe ? r_dq : {SDR_DW{1'bz}};
  assign wb_ack                                   = r_ack;
  assign wb_dato                                  = r_dato;

  // Main sequencer: init, refresh and access steps; all SDRAM pins come straight from registers.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state  <= S_INIT;
      r_cnt    <= 16'd0;
      r_cke    <= 1'b0;
      r_cmd    <= CMD_INH;
      r_dqm    <= {SDR_BW{1'b1}};
      r_ba     <= 2'b00;
      r_addr   <= 13'd0;
      r_dq     <= {SDR_DW{1'b0}};
      r_dq_oe  <= 1'b0;
      r_ack    <= 1'b0;
      r_dato   <= {dw{1'b0}};
      r_rd_lo  <= {SDR_DW{1'b0}};
      r_we     <= 1'b0;
      r_sel    <= 4'd0;
      r_dati   <= {dw{1'b0}};
      r_col    <= 11'd0;
      r_ref_en <= 1'b0;
    end else begin
      r_cmd   <= CMD_NOP;
      r_dqm   <= {SDR_BW{1'b1}};
      r_dq_oe <= 1'b0;
      r_ack   <= 1'b0;
      r_cnt   <= r_cnt + 16'd1;
      case (r_state)
        S_INIT: begin
          r_cke <= 1'b1;
          if (r_cnt == L_INIT) begin
            r_cmd   <= CMD_PRE;
            r_addr  <= 13'h400;
            r_state <= S_WRP;
            r_cnt   <= 16'd0;
          end
        end
        S_WRP: if (r_cnt == L_RP) begin
          r_cmd   <= CMD_REF;
          r_state <= S_WRFC1;
          r_cnt   <= 16'd0;
        end
        S_WRFC1: if (r_cnt == L_RFC) begin
          r_cmd   <= CMD_REF;
          r_state <= S_WRFC2;
          r_cnt   <= 16'd0;
        end
        S_WRFC2: if (r_cnt == L_RFC) begin
          r_cmd   <= CMD_MRS;
          r_ba    <= 2'b00;
          r_addr  <= 13'h031;
          r_state <= S_WMRS;
          r_cnt   <= 16'd0;
        end
        S_WMRS: if (r_cnt == 16'd1) begin
          r_state  <= S_IDLE;
          r_ref_en <= 1'b1;
        end
        S_IDLE: begin
          if (r_ref_pend) begin
            r_cmd   <= CMD_REF;
            r_state <= S_WREF;
            r_cnt   <= 16'd0;
          end else if (wb_cyc && wb_stb) begin
            r_cmd   <= CMD_ACT;
            r_ba    <= w_ba;
            r_addr  <= w_row;
            r_col   <= w_col;
            r_we    <= wb_we;
            r_sel   <= wb_sel;
            r_dati  <= wb_dati;
            r_state <= S_ACC;
            r_cnt   <= 16'd0;
          end
        end
        S_WREF: if (r_cnt == L_RFC) r_state <= S_IDLE;
        S_ACC: begin
          // The whole burst runs off the latched request, so dropping wb_cyc cannot abort it.
          if (r_cnt == L_CMD) begin
            r_cmd  <= r_we ? CMD_WR : CMD_RD;
            r_addr <= 13'h400 | {2'b00, r_col};
            r_dq   <= r_dati[SDR_DW-1:0];
            r_dq_oe <= r_we;
            r_dqm  <= r_we ? ~r_sel[SDR_BW-1:0] : {SDR_BW{1'b0}};
          end else if (r_cnt == L_BEAT1) begin
            r_dq    <= r_dati[2*SDR_DW-1:SDR_DW];
            r_dq_oe <= r_we;
            r_dqm   <= r_we ? ~r_sel[2*SDR_BW-1:SDR_BW] : {SDR_BW{1'b0}};
          end else if (!r_we && (r_cnt > L_BEAT1) && (r_cnt <= L_RD_CAP)) begin
            r_dqm <= {SDR_BW{1'b0}};
          end
          if (!r_we && (r_cnt == L_RD_CAP)) r_rd_lo <= sdr_dq;
          if (r_cnt == (r_we ? L_WACK : L_RACK)) begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
            if (!r_we) r_dato <= {sdr_dq, r_rd_lo};
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Free-running refresh interval timer; pending is raised each interval and dropped when a REF completes.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_ref_cnt  <= 16'd0;
      r_ref_pend <= 1'b0;
    end else if (!r_ref_en) begin
      r_ref_cnt  <= 16'd0;
      r_ref_pend <= 1'b0;
    end else if (r_ref_cnt == L_REF) begin
      r_ref_cnt  <= 16'd0;
      r_ref_pend <= 1'b1;
    end else begin
      r_ref_cnt <= r_ref_cnt + 16'd1;
      if ((r_state == S_WREF) && (r_cnt == L_RFC)) r_ref_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modport_if.sv
// Directed bench for modport_if: init sequence, write/read bursts, byte masks, refresh priority, reset abort.
module tb_modport_if;

  localparam logic [3:0] C_INH = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic [1:0]  cfg_colbits;
  logic        wb_stb, wb_cyc, wb_we;
  logic [25:0] wb_addr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dati;
  logic [2:0]  wb_cti;
  logic [31:0] wb_dato;
  logic        wb_ack;
  logic        sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
  logic [1:0]  sdr_dqm, sdr_ba;
  logic [12:0] sdr_addr;
  wire  [15:0] sdr_dq;
  logic [15:0] tb_dq;
  logic        tb_dq_oe;
  logic [3:0]  cmd;

  int cyc = 0;
  int ack_cnt = 0;
  int n_vec = 0;
  int n_err = 0;
  int r0, r1, t, ack_base;

  assign sdr_dq = tb_dq_oe ? tb_dq : 16'hzzzz;
  assign cmd    = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};

  modport_if dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .cfg_colbits(cfg_colbits),
    .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_sel(wb_sel), .wb_dati(wb_dati), .wb_cti(wb_cti),
    .wb_dato(wb_dato), .wb_ack(wb_ack),
    .sdr_cke(sdr_cke), .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n),
    .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n), .sdr_dqm(sdr_dqm),
    .sdr_ba(sdr_ba), .sdr_addr(sdr_addr), .sdr_dq(sdr_dq)
  );

  always #5 wb_clk = ~wb_clk;

  always @(posedge wb_clk) cyc <= cyc + 1;

  always @(negedge wb_clk) if (wb_ack) ack_cnt <= ack_cnt + 1;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic goto_cyc(input int n);
    do @(negedge wb_clk); while (cyc < n);
  endtask

  task automatic check_cmd(input string tag, input logic [3:0] exp);
    check_vec(tag, {28'd0, cmd}, {28'd0, exp});
  endtask

  task automatic wb_start(input logic we, input logic [1:0] cb, input logic [25:0] a,
                          input logic [31:0] d, input logic [3:0] s, output int ts);
    cfg_colbits = cb;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_addr = a; wb_dati = d; wb_sel = s;
    ts = cyc + 1;
  endtask

  task automatic wb_drop();
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic do_write(input string nm, input logic [1:0] cb, input logic [25:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] e_ba, input logic [12:0] e_row, input logic [12:0] e_cadr,
                          input logic [15:0] e_dq0, input logic [15:0] e_dq1,
                          input logic [1:0] e_dqm0, input logic [1:0] e_dqm1, input logic drop_early);
    int ts;
    wb_start(1'b1, cb, a, d, s, ts);
    goto_cyc(ts);
    check_cmd({nm, "_act"}, C_ACT);
    check_vec({nm, "_act_ba"}, {30'd0, sdr_ba}, {30'd0, e_ba});
    check_vec({nm, "_act_row"}, {19'd0, sdr_addr}, {19'd0, e_row});
    if (drop_early) begin
      goto_cyc(ts + 1);
      wb_drop();
    end
    goto_cyc(ts + 2);
    check_cmd({nm, "_wr"}, C_WR);
    check_vec({nm, "_wr_addr"}, {19'd0, sdr_addr}, {19'd0, e_cadr});
    check_vec({nm, "_dq0"}, {16'd0, sdr_dq}, {16'd0, e_dq0});
    check_vec({nm, "_dqm0"}, {30'd0, sdr_dqm}, {30'd0, e_dqm0});
    goto_cyc(ts + 3);
    check_cmd({nm, "_nop1"}, C_NOP);
    check_vec({nm, "_dq1"}, {16'd0, sdr_dq}, {16'd0, e_dq1});
    check_vec({nm, "_dqm1"}, {30'd0, sdr_dqm}, {30'd0, e_dqm1});
    goto_cyc(ts + 4);
    check_vec({nm, "_dqm_after"}, {30'd0, sdr_dqm}, 32'h3);
    goto_cyc(ts + 6);
    check_vec({nm, "_ack_early"}, {31'd0, wb_ack}, 32'd0);
    goto_cyc(ts + 7);
    check_vec({nm, "_ack"}, {31'd0, wb_ack}, 32'd1);
    wb_drop();
    goto_cyc(ts + 8);
    check_vec({nm, "_ack_pulse"}, {31'd0, wb_ack}, 32'd0);
  endtask

  task automatic do_read(input string nm, input logic [1:0] cb, input logic [25:0] a,
                         input logic [15:0] lo, input logic [15:0] hi,
                         input logic [1:0] e_ba, input logic [12:0] e_row, input logic [12:0] e_cadr,
                         input logic [31:0] e_dato, input logic [31:0] prev_dato);
    int ts;
    wb_start(1'b0, cb, a, 32'h0, 4'hF, ts);
    goto_cyc(ts);
    check_cmd({nm, "_act"}, C_ACT);
    check_vec({nm, "_act_ba"}, {30'd0, sdr_ba}, {30'd0, e_ba});
    check_vec({nm, "_act_row"}, {19'd0, sdr_addr}, {19'd0, e_row});
    goto_cyc(ts + 2);
    check_cmd({nm, "_rd"}, C_RD);
    check_vec({nm, "_rd_addr"}, {19'd0, sdr_addr}, {19'd0, e_cadr});
    check_vec({nm, "_rd_dqm"}, {30'd0, sdr_dqm}, 32'd0);
    goto_cyc(ts + 5);
    tb_dq = lo; tb_dq_oe = 1'b1;
    goto_cyc(ts + 6);
    tb_dq = hi;
    check_vec({nm, "_ack_early"}, {31'd0, wb_ack}, 32'd0);
    check_vec({nm, "_dato_hold"}, wb_dato, prev_dato);
    goto_cyc(ts + 7);
    tb_dq_oe = 1'b0;
    check_vec({nm, "_ack"}, {31'd0, wb_ack}, 32'd1);
    check_vec({nm, "_dato"}, wb_dato, e_dato);
    wb_drop();
    goto_cyc(ts + 8);
    check_vec({nm, "_ack_pulse"}, {31'd0, wb_ack}, 32'd0);
  endtask

  task automatic check_reset_outs(input string nm);
    check_vec({nm, "_cke"}, {31'd0, sdr_cke}, 32'd0);
    check_cmd({nm, "_cmd"}, C_INH);
    check_vec({nm, "_dqm"}, {30'd0, sdr_dqm}, 32'h3);
    check_vec({nm, "_ba"}, {30'd0, sdr_ba}, 32'd0);
    check_vec({nm, "_addr"}, {19'd0, sdr_addr}, 32'd0);
    check_vec({nm, "_ack"}, {31'd0, wb_ack}, 32'd0);
    check_vec({nm, "_dato"}, wb_dato, 32'd0);
  endtask

  task automatic check_init(input string nm, input int base);
    goto_cyc(base + 1);
    check_vec({nm, "_cke_on"}, {31'd0, sdr_cke}, 32'd1);
    check_cmd({nm, "_nop_first"}, C_NOP);
    goto_cyc(base + 100);
    check_cmd({nm, "_nop_last"}, C_NOP);
    goto_cyc(base + 101);
    check_cmd({nm, "_pre"}, C_PRE);
    check_vec({nm, "_pre_a10"}, {31'd0, sdr_addr[10]}, 32'd1);
    goto_cyc(base + 102);
    check_cmd({nm, "_trp_nop"}, C_NOP);
    goto_cyc(base + 103);
    check_cmd({nm, "_ref1"}, C_REF);
    goto_cyc(base + 109);
    check_cmd({nm, "_trfc_nop"}, C_NOP);
    goto_cyc(base + 110);
    check_cmd({nm, "_ref2"}, C_REF);
  endtask

  initial begin
    cfg_colbits = 2'b01;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    wb_addr = 26'd0; wb_sel = 4'd0; wb_dati = 32'd0; wb_cti = 3'd0;
    tb_dq = 16'd0; tb_dq_oe = 1'b0;

    repeat (3) @(negedge wb_clk);
    check_reset_outs("rst");

    // A request held through init must be ignored.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 26'h10;
    wb_rst = 1'b0;
    r0 = cyc;
    check_init("init", r0);
    goto_cyc(r0 + 115);
    wb_drop();
    goto_cyc(r0 + 117);
    check_cmd("init_mrs", C_MRS);
    check_vec("init_mrs_addr", {19'd0, sdr_addr}, 32'h031);
    goto_cyc(r0 + 118);
    check_vec("init_no_ack", ack_cnt, 32'd0);

    goto_cyc(r0 + 120);
    do_write("w1", 2'b01, 26'h000_0010, 32'hA5A5_1234, 4'hF,
             2'd0, 13'h000, 13'h408, 16'h1234, 16'hA5A5, 2'b00, 2'b00, 1'b0);
    do_read("r1", 2'b01, 26'h000_0010, 16'h1234, 16'hA5A5,
            2'd0, 13'h000, 13'h408, 32'hA5A5_1234, 32'h0);
    do_write("w_sel4", 2'b10, 26'h012_3458, 32'hDEAD_BEEF, 4'b0100,
             2'd2, 13'h091, 13'h62C, 16'hBEEF, 16'hDEAD, 2'b11, 2'b10, 1'b1);
    check_vec("dato_keep_after_wr", wb_dato, 32'hA5A5_1234);
    do_write("w_cb0", 2'b00, 26'h004_0C08, 32'h0123_4567, 4'b1001,
             2'd2, 13'h081, 13'h404, 16'h4567, 16'h0123, 2'b10, 2'b01, 1'b0);
    do_read("r_top", 2'b11, 26'h3FF_FFFC, 16'h5A5A, 16'h0F0F,
            2'd3, 13'h0FFF, 13'h7FE, 32'h0F0F_5A5A, 32'hA5A5_1234);

    // Periodic refresh: first deadline counted from the first IDLE cycle.
    goto_cyc(r0 + 899);
    check_cmd("ref1_not_yet", C_NOP);
    goto_cyc(r0 + 900);
    check_cmd("ref1_periodic", C_REF);

    // Request arrives exactly with the next deadline: REF must go first.
    goto_cyc(r0 + 1679);
    ack_base = ack_cnt;
    wb_start(1'b1, 2'b01, 26'h000_0010, 32'h1111_2222, 4'hF, t);
    goto_cyc(r0 + 1680);
    check_cmd("refprio_ref", C_REF);
    goto_cyc(r0 + 1687);
    check_cmd("refprio_wait", C_NOP);
    goto_cyc(r0 + 1688);
    check_cmd("refprio_act", C_ACT);
    goto_cyc(r0 + 1690);
    check_cmd("refprio_wr", C_WR);
    check_vec("refprio_dq0", {16'd0, sdr_dq}, 32'h2222);
    goto_cyc(r0 + 1695);
    check_vec("refprio_ack", {31'd0, wb_ack}, 32'd1);
    wb_drop();
    goto_cyc(r0 + 1700);
    check_vec("refprio_one_ack", ack_cnt - ack_base, 32'd1);

    // Reset in the middle of a write.
    ack_base = ack_cnt;
    wb_start(1'b1, 2'b01, 26'h000_0020, 32'hCAFE_F00D, 4'hF, t);
    goto_cyc(t + 4);
    wb_rst = 1'b1;
    #1;
    check_reset_outs("midrst");
    wb_drop();
    goto_cyc(t + 8);
    wb_rst = 1'b0;
    r1 = cyc;
    check_init("reinit", r1);
    check_vec("midrst_no_ack", ack_cnt - ack_base, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
